mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store access controller between a pipeline MEM stage and a word-wide memory port.
// Handles byte/half/word lane steering, sign/zero extension, alignment checks and a bounded wait for mem_ready.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_option,
    output logic        stall,
    output logic        done,
    output logic        error,
    output logic [31:0] rdata_out,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [2:0]  lat_option;
    logic [1:0]  lat_off;
    logic        lat_we;

    logic        illegal;
    logic        misaligned;
    logic [3:0]  strobe;
    logic [31:0] lane_wdata;

    // Width code decode uses option[1:0]; the unsigned variants share lane rules with their signed twins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        illegal    = (req_option == 3'b011) || (req_option[2:1] == 2'b11);
        misaligned = 1'b0;
        strobe     = 4'b1111;
        lane_wdata = req_wdata;
        case (req_option[1:0])
            2'b00: begin
                strobe     = 4'b0001 << req_addr[1:0];
                lane_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = req_addr[0];
                strobe     = req_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{req_wdata[15:0]}};
            end
            2'b10: misaligned = (req_addr[1:0] != 2'b00);
            default: ;
        endcase
    end

    function automatic logic [31:0] load_ext(input logic [2:0]  opt,
                                             input logic [1:0]  off,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (opt)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            default: return word;
        endcase
    endfunction

    assign stall = req_valid && (state != RESP);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            lat_option <= '0;
            lat_off    <= '0;
            lat_we     <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            rdata_out  <= '0;
            mem_en     <= 1'b0;
            mem_we     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            // NOTE: non-blocking assignments only, so every register sees pre-edge values of the others.
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (illegal || misaligned) begin
                            state     <= RESP;
                            done      <= 1'b1;
                            error     <= 1'b1;
                            rdata_out <= '0;
                        end else begin
                            state      <= ACCESS;
                            wait_cnt   <= '0;
                            lat_option <= req_option;
                            lat_off    <= req_addr[1:0];
                            lat_we     <= req_we;
                            mem_en     <= 1'b1;
                            mem_addr   <= {req_addr[31:2], 2'b00};
                            mem_we     <= req_we ? strobe : 4'b0000;
                            mem_wdata  <= req_we ? lane_wdata : 32'h0;
                        end
                    end
                end
                ACCESS: begin
                    // Completion is tested first so a ready on the final wait cycle still succeeds.
                    if (mem_ready) begin
                        state     <= RESP;
                        done      <= 1'b1;
                        mem_en    <= 1'b0;
                        mem_we    <= '0;
                        rdata_out <= lat_we ? 32'h0 : load_ext(lat_option, lat_off, mem_rdata);
                    end else if (wait_cnt == LAST_WAIT) begin
                        state     <= RESP;
                        done      <= 1'b1;
                        error     <= 1'b1;
                        mem_en    <= 1'b0;
                        mem_we    <= '0;
                        rdata_out <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
